sniff_deserializer: RTL and testbench

//  Sits directly downstream of the data sniffer.

---
 rtl/sniff_deserializer_if.sv | 38 +++
 rtl/sniff_deserializer.sv | 143 ++++++++++++++
 tb/tb_sniff_deserializer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sniff_deserializer_if.sv
// Serial-in / word-out bus of sniff_deserializer.
// OutParity exists only when DESER_PARITY_EN is defined.
interface sniff_deserializer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic             DataIn;
    logic             RecordFlag;
    logic [WIDTH-1:0] OutData;
    logic [BW-1:0]    OutBits;
    logic             OutLast;
    logic             OutValid;
    logic             OutReady;
    logic [LW-1:0]    FifoLevel;
    logic             Overflow;
`ifdef DESER_PARITY_EN
    logic             OutParity;
`endif

    modport slave (
        input  DataIn, RecordFlag, OutReady,
        output OutData, OutBits, OutLast, OutValid, FifoLevel, Overflow
`ifdef DESER_PARITY_EN
        , output OutParity
`endif
    );

    modport master (
        output DataIn, RecordFlag, OutReady,
        input  OutData, OutBits, OutLast, OutValid, FifoLevel, Overflow
`ifdef DESER_PARITY_EN
        , input OutParity
`endif
    );
endinterface

// File: rtl/sniff_deserializer.sv
// Packs sniffer frames MSB-first into WIDTH-bit words and queues them in a FWFT FIFO.
// Define DESER_PARITY_EN to store and present a per-entry OutParity bit.
module sniff_deserializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    sniff_deserializer_if.slave bus
);
    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [BW-1:0]    bits;
        logic             last;
`ifdef DESER_PARITY_EN
        logic             parity;
`endif
    } entry_t;

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    logic             push, pop, full, push_ok;
    entry_t           push_entry;
    logic [WIDTH-1:0] shifted;
    logic [BW-1:0]    cnt_inc;
    logic [AW-1:0]    wr_idx;

    // Capture FSM: builds words and frame tails, at most one push per cycle
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_entry = '0;
        shifted    = {shreg_q[WIDTH-2:0], bus.DataIn};
        cnt_inc    = cnt_q + BW'(1);
        case (state_q)
            IDLE: begin
                if (bus.RecordFlag) begin
                    shreg_d = WIDTH'(bus.DataIn);
                    cnt_d   = BW'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.RecordFlag) begin
                    if (cnt_inc == BW'(WIDTH)) begin
                        push            = 1'b1;
                        push_entry.data = shifted;
                        push_entry.bits = BW'(WIDTH);
`ifdef DESER_PARITY_EN
                        push_entry.parity = ^shifted;
`endif
                        shreg_d = '0;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    // Unused low bits are zero, so the shift both aligns and pads; count 0 yields the terminator
                    push            = 1'b1;
                    push_entry.data = shreg_q << (BW'(WIDTH) - cnt_q);
                    push_entry.bits = cnt_q;
                    push_entry.last = 1'b1;
`ifdef DESER_PARITY_EN
                    push_entry.parity = ^shreg_q;
`endif
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifting queue: slot 0 is always the head, slots at or above the level stay zero
    always_comb begin
        full       = (level_q == LW'(DEPTH));
        pop        = valid_q & bus.OutReady;
        push_ok    = push & (~full | pop);
        overflow_d = overflow_q | (push & full & ~pop);
        wr_idx     = AW'(level_q - LW'(pop));
        mem_d      = mem_q;
        if (pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
        end
        if (push_ok) begin
            mem_d[wr_idx] = push_entry;
        end
        level_d = level_q + LW'(push_ok) - LW'(pop);
        valid_d = (level_d != '0);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.OutData   = mem_q[0].data;
    assign bus.OutBits   = mem_q[0].bits;
    assign bus.OutLast   = mem_q[0].last;
    assign bus.OutValid  = valid_q;
    assign bus.FifoLevel = level_q;
    assign bus.Overflow  = overflow_q;
`ifdef DESER_PARITY_EN
    assign bus.OutParity = mem_q[0].parity;
`endif
endmodule

// File: tb/tb_sniff_deserializer.sv
// Self-checking bench for sniff_deserializer against a queue-based frame model.
module tb_sniff_deserializer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BW    = $clog2(WIDTH + 1);
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic CLK = 1'b0;
    logic Reset;

    sniff_deserializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    sniff_deserializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        int         bits;
        bit         last;
        bit         par;
    } ent_t;

    ent_t mq[$];
    bit   cur[$];
    bit   in_frame = 1'b0;
    bit   m_ovf    = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic ent_t make_ent(bit last);
        ent_t e;
        e.data = '0;
        e.par  = 1'b0;
        foreach (cur[i]) begin
            e.data[WIDTH-1-i] = cur[i];
            e.par ^= cur[i];
        end
        e.bits = cur.size();
        e.last = last;
        return e;
    endfunction

    function automatic ent_t head();
        ent_t e = '{default: 0};
        if (mq.size() > 0) e = mq[0];
        return e;
    endfunction

    // Drive one cycle of inputs and advance the reference model by the same edge
    task automatic step(bit rst, bit rf, bit din, bit rdy);
        ent_t e;
        bit   do_push;
        bit   do_pop;
        Reset          = rst;
        bus.RecordFlag = rf;
        bus.DataIn     = din;
        bus.OutReady   = rdy;
        @(posedge CLK);
        if (rst) begin
            mq.delete();
            cur.delete();
            in_frame = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            do_push = 1'b0;
            do_pop  = (mq.size() > 0) && rdy;
            if (rf) begin
                cur.push_back(din);
                in_frame = 1'b1;
                if (cur.size() == WIDTH) begin
                    e = make_ent(1'b0);
                    cur.delete();
                    do_push = 1'b1;
                end
            end else if (in_frame) begin
                e = make_ent(1'b1);
                cur.delete();
                in_frame = 1'b0;
                do_push  = 1'b1;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(e);
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic send_bits(logic [7:0] v, int n, bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, v[7-i], rdy);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.OutValid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b exp 0", bus.OutValid); end
        n_checks++; if (bus.FifoLevel !== LW'(0)) begin n_errors++; $display("FAIL reset_level: got %0d exp 0", bus.FifoLevel); end
        n_checks++; if (bus.Overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b exp 0", bus.Overflow); end
        n_checks++; if ({bus.OutData, bus.OutBits, bus.OutLast} !== '0) begin n_errors++;
            $display("FAIL reset_head: got %h/%0d/%b exp 0/0/0", bus.OutData, bus.OutBits, bus.OutLast); end
    endtask

    task automatic test_word_and_terminator();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hB2, 8, 1'b1);
        n_checks++; if ({bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast} !== {1'b1, 8'hB2, BW'(8), 1'b0}) begin n_errors++;
            $display("FAIL word_head: got v%b %h/%0d/%b exp v1 b2/8/0", bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast} !== {1'b1, 8'h00, BW'(0), 1'b1}) begin n_errors++;
            $display("FAIL term_head: got v%b %h/%0d/%b exp v1 00/0/1", bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.OutValid !== 1'b0) begin n_errors++; $display("FAIL term_drain: got valid %b exp 0", bus.OutValid); end
    endtask

    task automatic test_short_tail();
        send_bits(8'hC0, 3, 1'b0);
        n_checks++; if (bus.OutValid !== 1'b0) begin n_errors++; $display("FAIL tail_early: got valid %b exp 0", bus.OutValid); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast} !== {1'b1, 8'hC0, BW'(3), 1'b1}) begin n_errors++;
            $display("FAIL tail_head: got v%b %h/%0d/%b exp v1 c0/3/1", bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.FifoLevel !== LW'(0)) begin n_errors++; $display("FAIL tail_drain: got level %0d exp 0", bus.FifoLevel); end
    endtask

    task automatic test_overflow();
        logic [7:0] w [3];
        logic [7:0] ed [4];
        logic [BW-1:0] eb [4];
        logic el [4];
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            w[f] = 8'($urandom);
            send_bits(w[f], 8, 1'b0);
            if (f == 2) begin
                n_checks++; if (bus.Overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_fifth: got %b exp 1", bus.Overflow); end
            end
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (f == 1) begin
                n_checks++; if ({bus.FifoLevel, bus.Overflow} !== {LW'(4), 1'b0}) begin n_errors++;
                    $display("FAIL ovf_fourth: got level %0d ovf %b exp 4/0", bus.FifoLevel, bus.Overflow); end
            end
        end
        n_checks++; if (bus.FifoLevel !== LW'(4)) begin n_errors++; $display("FAIL ovf_level: got %0d exp 4", bus.FifoLevel); end
        ed = '{w[0], 8'h00, w[1], 8'h00};
        eb = '{BW'(8), BW'(0), BW'(8), BW'(0)};
        el = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            n_checks++; if ({bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast} !== {1'b1, ed[k], eb[k], el[k]}) begin n_errors++;
                $display("FAIL ovf_entry%0d: got v%b %h/%0d/%b exp v1 %h/%0d/%b", k, bus.OutValid, bus.OutData, bus.OutBits,
                         bus.OutLast, ed[k], eb[k], el[k]); end
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        n_checks++; if ({bus.OutValid, bus.Overflow} !== 2'b01) begin n_errors++;
            $display("FAIL ovf_sticky: got valid %b ovf %b exp 0/1", bus.OutValid, bus.Overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] w0, w1, w2;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
        send_bits(w0, 8, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(w1, 8, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(w2, 7, 1'b0);
        step(1'b0, 1'b1, w2[0], 1'b1);
        n_checks++; if ({bus.FifoLevel, bus.Overflow, bus.OutData, bus.OutBits, bus.OutLast} !== {LW'(4), 1'b0, 8'h00, BW'(0), 1'b1}) begin
            n_errors++; $display("FAIL full_pp1: got level %0d ovf %b head %h/%0d/%b exp 4 0 00/0/1", bus.FifoLevel, bus.Overflow,
                                 bus.OutData, bus.OutBits, bus.OutLast); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({bus.FifoLevel, bus.Overflow, bus.OutData, bus.OutBits, bus.OutLast} !== {LW'(4), 1'b0, w1, BW'(8), 1'b0}) begin
            n_errors++; $display("FAIL full_pp2: got level %0d ovf %b head %h/%0d/%b exp 4 0 %h/8/0", bus.FifoLevel, bus.Overflow,
                                 bus.OutData, bus.OutBits, bus.OutLast, w1); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'($urandom), 5, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if ({bus.OutValid, bus.FifoLevel} !== {1'b0, LW'(0)}) begin n_errors++;
            $display("FAIL rst_mid: got valid %b level %0d exp 0/0", bus.OutValid, bus.FifoLevel); end
        w = 8'($urandom);
        send_bits(w, 8, 1'b1);
        n_checks++; if ({bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast} !== {1'b1, w, BW'(8), 1'b0}) begin n_errors++;
            $display("FAIL rst_next_word: got v%b %h/%0d/%b exp v1 %h/8/0", bus.OutValid, bus.OutData, bus.OutBits, bus.OutLast, w); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.FifoLevel !== LW'(0)) begin n_errors++; $display("FAIL rst_next_drain: got level %0d exp 0", bus.FifoLevel); end
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hB2, 8, 1'b0);
        n_checks++; if (bus.OutParity !== 1'b0) begin n_errors++; $display("FAIL par_b2: got %b exp 0", bus.OutParity); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({bus.OutLast, bus.OutParity} !== 2'b10) begin n_errors++;
            $display("FAIL par_term: got last %b par %b exp 1/0", bus.OutLast, bus.OutParity); end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({bus.OutData, bus.OutBits, bus.OutLast, bus.OutParity} !== {8'h80, BW'(3), 1'b1, 1'b1}) begin n_errors++;
            $display("FAIL par_100: got %h/%0d/%b par %b exp 80/3/1 par 1", bus.OutData, bus.OutBits, bus.OutLast, bus.OutParity); end
    endtask
`endif

    task automatic test_random();
        ent_t h;
        bit   rdy;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 1200; c++) begin
            rdy = ((c / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, 1'($urandom), rdy);
            h = head();
            n_checks++; if (bus.OutValid !== (mq.size() > 0)) begin n_errors++;
                $display("FAIL rnd_valid c%0d: got %b exp %b", c, bus.OutValid, mq.size() > 0); end
            n_checks++; if (bus.FifoLevel !== LW'(mq.size())) begin n_errors++;
                $display("FAIL rnd_level c%0d: got %0d exp %0d", c, bus.FifoLevel, mq.size()); end
            n_checks++; if (bus.Overflow !== m_ovf) begin n_errors++;
                $display("FAIL rnd_ovf c%0d: got %b exp %b", c, bus.Overflow, m_ovf); end
            n_checks++; if ({bus.OutData, bus.OutBits, bus.OutLast} !== {h.data, BW'(h.bits), h.last}) begin n_errors++;
                $display("FAIL rnd_head c%0d: got %h/%0d/%b exp %h/%0d/%b", c, bus.OutData, bus.OutBits, bus.OutLast,
                         h.data, h.bits, h.last); end
`ifdef DESER_PARITY_EN
            n_checks++; if (bus.OutParity !== h.par) begin n_errors++;
                $display("FAIL rnd_par c%0d: got %b exp %b", c, bus.OutParity, h.par); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_word_and_terminator();
        test_short_tail();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
`ifdef DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
